// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle control sequencer for the 16-bit CPU. It fetches an instruction
// word through a ready handshake, latches the opcode, and then drives the ALU
// mode and the load/increment strobes for the operand registers, register
// file, instruction splitter and program counter. Instructions that carry
// extension words (MVI, LDA) loop through EXT_FETCH/EXT_EXEC once per word.
// The final execute cycle of one instruction is followed directly by the
// FETCH of the next.
//
// Parameters:
//   OPCODE_W  opcode width; bits above [3:0] must be zero for a legal opcode
//   ALU_OT_W  ALU operation-type width
//   LDA_EXT   number of extension words consumed by LDA (1 .. 2**CNT_W-1)
//   CNT_W     width of the extension-word counter
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         sequencer enable; 0 forces every output low immediately
//   ins_ready  instruction memory presents a valid word this cycle
//   opcode     opcode field of the current instruction word
//   alu_ot     ALU mode: 00 addressing, 01 arithmetic, 10 logic
//   ins_load   instruction splitter load strobe
//   pc_load    PC-to-memory address load strobe
//   pc_inc     PC increment strobe (once per instruction word consumed)
//   op1_load   operand-1 load strobe
//   op2_load   operand-2 load strobe
//   reg_load   register-file write strobe
//   instr_done one-cycle pulse in the final execute cycle of an instruction
//   trap       illegal-opcode trap
//
// Build option:
//   CTRL_SEQ_TRAP_EN  when defined, an illegal opcode parks the sequencer in
//                     TRAP (trap=1) until en drops or reset. When undefined,
//                     an illegal opcode executes as a NOP and trap is tied 0.
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OT_W = 2,
    parameter int LDA_EXT  = 1,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                ins_ready,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALU_OT_W-1:0] alu_ot,
    output logic                ins_load,
    output logic                pc_load,
    output logic                pc_inc,
    output logic                op1_load,
    output logic                op2_load,
    output logic                reg_load,
    output logic                instr_done,
    output logic                trap
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        EXT_FETCH,
        EXT_EXEC,
        TRAP
    } state_t;

    localparam logic [3:0] OP_INV1 = 4'h7;
    localparam logic [3:0] OP_INV2 = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_MVI  = 4'hC;
    localparam logic [3:0] OP_LDA  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;

    localparam logic [ALU_OT_W-1:0] ALU_ADDR  = '0;
    localparam logic [ALU_OT_W-1:0] ALU_ARITH = ALU_OT_W'(1);
    localparam logic [ALU_OT_W-1:0] ALU_LOGIC = ALU_OT_W'(2);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state;
    state_t              state_next;
    logic [OPCODE_W-1:0] cur_op;
    logic [CNT_W-1:0]    cnt;

    logic [3:0]          op_lo;
    logic                op_legal;
    logic [CNT_W-1:0]    exec_cnt;
    logic                last_ext;
    logic                trap_s;

    // ------------------------------------------------------------------
    // Decode of the latched opcode (never of the live opcode input, so the
    // outputs carry no combinational path from opcode).
    // ------------------------------------------------------------------
    assign op_lo    = cur_op[3:0];
    assign op_legal = ((cur_op >> 4) == '0) && (op_lo != 4'hF);

    // Number of extension words still to consume once EXEC completes.
    always_comb begin
        exec_cnt = '0;
        if (op_legal) begin
            case (op_lo)
                OP_MVI:  exec_cnt = CNT_ONE;
                OP_LDA:  exec_cnt = CNT_W'(LDA_EXT);
                default: exec_cnt = '0;
            endcase
        end
    end

    // cnt <= 1 rather than == 1 so a corrupted zero count still terminates.
    assign last_ext = (cnt <= CNT_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched opcode and extension-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op <= '0;
            cnt    <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (ins_ready) begin
                        cur_op <= opcode;
                    end
                end
                EXEC: begin
                    cnt <= exec_cnt;
                end
                EXT_EXEC: begin
                    cnt <= cnt - CNT_ONE;
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational block assigns defaults first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (ins_ready) begin
                        state_next = EXEC;
                    end
                end
                EXEC: begin
`ifdef CTRL_SEQ_TRAP_EN
                    if (!op_legal) begin
                        state_next = TRAP;
                    end else if (exec_cnt != '0) begin
                        state_next = EXT_FETCH;
                    end else begin
                        state_next = FETCH;
                    end
`else
                    if (exec_cnt != '0) begin
                        state_next = EXT_FETCH;
                    end else begin
                        state_next = FETCH;
                    end
`endif
                end
                EXT_FETCH: begin
                    if (ins_ready) begin
                        state_next = EXT_EXEC;
                    end
                end
                EXT_EXEC: begin
                    state_next = last_ext ? FETCH : EXT_FETCH;
                end
                TRAP: begin
                    state_next = TRAP;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs: state and cur_op only, gated by en.
    // ------------------------------------------------------------------
    always_comb begin
        alu_ot     = ALU_ADDR;
        ins_load   = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        op1_load   = 1'b0;
        op2_load   = 1'b0;
        reg_load   = 1'b0;
        instr_done = 1'b0;
        trap_s     = 1'b0;

        if (en) begin
            case (state)
                FETCH, EXT_FETCH: begin
                    ins_load = 1'b1;
                    pc_load  = 1'b1;
                end

                EXEC: begin
                    if (op_legal) begin
                        pc_inc     = 1'b1;
                        instr_done = (exec_cnt == '0);
                        case (op_lo)
                            4'h0, 4'h1, 4'h2, 4'h3: begin
                                alu_ot   = ALU_ARITH;
                                op1_load = 1'b1;
                                op2_load = 1'b1;
                                reg_load = 1'b1;
                            end
                            4'h4, 4'h5, 4'h6, 4'h9, 4'hA: begin
                                alu_ot   = ALU_LOGIC;
                                op1_load = 1'b1;
                                op2_load = 1'b1;
                                reg_load = 1'b1;
                            end
                            OP_INV1: begin
                                alu_ot   = ALU_LOGIC;
                                op1_load = 1'b1;
                                reg_load = 1'b1;
                            end
                            OP_INV2: begin
                                alu_ot   = ALU_LOGIC;
                                op2_load = 1'b1;
                                reg_load = 1'b1;
                            end
                            OP_MOV: begin
                                op2_load = 1'b1;
                                reg_load = 1'b1;
                            end
                            OP_MVI: begin
                                op1_load = 1'b1;
                            end
                            OP_LDA, OP_NOP: begin
                                // Only pc_inc; LDA writes on its last word.
                            end
                            default: begin
                            end
                        endcase
                    end else begin
`ifdef CTRL_SEQ_TRAP_EN
                        // All strobes stay low on the way into TRAP.
`else
                        // Illegal opcode behaves as NOP.
                        pc_inc     = 1'b1;
                        instr_done = 1'b1;
`endif
                    end
                end

                EXT_EXEC: begin
                    pc_inc     = 1'b1;
                    instr_done = last_ext;
                    if (op_lo == OP_MVI) begin
                        op2_load = 1'b1;
                        reg_load = 1'b1;
                    end else if (op_lo == OP_LDA) begin
                        reg_load = (cnt == CNT_ONE);
                    end
                end

                TRAP: begin
`ifdef CTRL_SEQ_TRAP_EN
                    trap_s = 1'b1;
`endif
                end

                default: begin
                end
            endcase
        end
    end

    assign trap = trap_s;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer (LDA_EXT=3). Each cycle the
// stimulus driver pushes the expected output vector onto a scoreboard queue;
// the vector is popped and compared against the DUT at the falling edge.
// Expected vector layout:
//   {trap, instr_done, reg_load, op2_load, op1_load, pc_inc, pc_load,
//    ins_load, alu_ot[1:0]}
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ins_ready;
    logic [3:0] opcode;
    logic [1:0] alu_ot;
    logic       ins_load;
    logic       pc_load;
    logic       pc_inc;
    logic       op1_load;
    logic       op2_load;
    logic       reg_load;
    logic       instr_done;
    logic       trap;

    logic [9:0] obs;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];

    control_sequencer #(
        .OPCODE_W (4),
        .ALU_OT_W (2),
        .LDA_EXT  (3),
        .CNT_W    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ins_ready  (ins_ready),
        .opcode     (opcode),
        .alu_ot     (alu_ot),
        .ins_load   (ins_load),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .op1_load   (op1_load),
        .op2_load   (op2_load),
        .reg_load   (reg_load),
        .instr_done (instr_done),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    assign obs = {trap, instr_done, reg_load, op2_load, op1_load,
                  pc_inc, pc_load, ins_load, alu_ot};

    task automatic check(input string tag, input logic [9:0] got,
                         input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] mk(input int alu, input bit il, input bit pl,
                                      input bit pi, input bit o1, input bit o2,
                                      input bit rl, input bit dn, input bit tr);
        logic [1:0] a;
        a = alu[1:0];
        return {tr, dn, rl, o2, o1, pi, pl, il, a};
    endfunction

    function automatic logic [9:0] none_v();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [9:0] fetch_v();
        return mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    // Expected EXEC-cycle outputs for single-word opcodes.
    function automatic logic [9:0] exec_v(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3:       return mk(1, 0, 0, 1, 1, 1, 1, 1, 0);
            4'h4, 4'h5, 4'h6, 4'h9, 4'hA: return mk(2, 0, 0, 1, 1, 1, 1, 1, 0);
            4'h7:                         return mk(2, 0, 0, 1, 1, 0, 1, 1, 0);
            4'h8:                         return mk(2, 0, 0, 1, 0, 1, 1, 1, 0);
            4'hB:                         return mk(0, 0, 0, 1, 0, 1, 1, 1, 0);
            4'hE:                         return mk(0, 0, 0, 1, 0, 0, 0, 1, 0);
            default:                      return none_v();
        endcase
    endfunction

    task automatic compare();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=%b expected=entry", obs);
        end else begin
            x = sb.pop_front();
            check(x.tag, obs, x.v);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expected outputs for this cycle, compare at the falling edge.
    task automatic step(input logic e, input logic r, input logic [3:0] op,
                        input logic [9:0] exp, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        en        = e;
        ins_ready = r;
        opcode    = op;
        x.tag     = tag;
        x.v       = exp;
        sb.push_back(x);
        @(negedge clk);
        compare();
    endtask

    initial begin : main
        int ops[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14};
        logic [3:0] op;
        exp_t x;

        rst_n     = 1'b1;
        en        = 1'b0;
        ins_ready = 1'b0;
        opcode    = 4'h0;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs, none_v());

        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_en_low", obs, none_v());

        // ADD from reset: IDLE, FETCH, EXEC, then back-to-back FETCH.
        step(1, 1, 4'h0, none_v(),  "idle_en_rise");
        step(1, 1, 4'h0, fetch_v(), "add_fetch");
        step(1, 1, 4'h5, exec_v(4'h0), "add_exec");

        // Remaining single-word opcodes back to back; the opcode input is
        // scrambled in EXEC to show only the latched value matters.
        for (int i = 0; i < 12; i++) begin
            op = ops[i][3:0];
            if (op == 4'h5) begin
                step(1, 0, op, fetch_v(), "fetch_stall");
            end
            step(1, 1, op, fetch_v(), $sformatf("fetch_op%0h", op));
            step(1, 1, ~op, exec_v(op), $sformatf("exec_op%0h", op));
        end

        // MVI with three stall cycles in EXT_FETCH: 7 cycles total.
        step(1, 1, 4'hC, fetch_v(), "mvi_fetch");
        step(1, 1, 4'h0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0), "mvi_exec");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 4'hF, fetch_v(), "mvi_ext_stall");
        end
        step(1, 1, 4'hF, fetch_v(), "mvi_ext_fetch");
        step(1, 1, 4'h0, mk(0, 0, 0, 1, 0, 1, 1, 1, 0), "mvi_ext_exec");

        // LDA with three extension words: 8 cycles, reg_load on the last.
        step(1, 1, 4'hD, fetch_v(), "lda_fetch");
        step(1, 1, 4'h0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0), "lda_exec");
        for (int k = 1; k <= 3; k++) begin
            step(1, 1, 4'h0, fetch_v(), $sformatf("lda_ext_fetch%0d", k));
            step(1, 1, 4'h0,
                 (k == 3) ? mk(0, 0, 0, 1, 0, 0, 1, 1, 0)
                          : mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
                 $sformatf("lda_ext_exec%0d", k));
        end

        // Illegal opcode.
        step(1, 1, 4'hF, fetch_v(), "illegal_fetch");
`ifdef CTRL_SEQ_TRAP_EN
        step(1, 1, 4'h0, none_v(), "illegal_exec");
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 4'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "trap_hold");
        end
        step(0, 1, 4'h0, none_v(), "trap_en_low");
        step(1, 1, 4'h0, none_v(), "idle_after_trap");
`else
        step(1, 1, 4'h0, mk(0, 0, 0, 1, 0, 0, 0, 1, 0), "illegal_as_nop");
`endif

        // Reset asserted during EXT_FETCH of MVI.
        step(1, 1, 4'hC, fetch_v(), "mvi2_fetch");
        step(1, 1, 4'h0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0), "mvi2_exec");
        step(1, 0, 4'h0, fetch_v(), "mvi2_ext_fetch");
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", obs, none_v());
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        en        = 1'b1;
        ins_ready = 1'b1;
        opcode    = 4'h0;
        x.tag     = "post_reset_idle";
        x.v       = none_v();
        sb.push_back(x);
        @(negedge clk);
        compare();
        step(1, 1, 4'h0, fetch_v(), "post_reset_fetch");
        step(1, 1, 4'h0, exec_v(4'h0), "post_reset_exec");

        // en dropped during EXEC of INV op1.
        step(1, 1, 4'h7, fetch_v(), "inv1_fetch");
        step(0, 1, 4'h0, none_v(), "en_drop_exec");
        step(1, 1, 4'h0, none_v(), "idle_after_drop");
        step(1, 1, 4'h3, fetch_v(), "restart_fetch");
        step(1, 1, 4'h0, exec_v(4'h3), "restart_exec");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control sequencer for the 16-bit CPU. It fetches an instruction word through a ready handshake and decodes the opcode. It then drives the ALU-type and load/increment strobes for the operand registers, register file, instruction splitter and program counter. Instructions may carry a variable number of extension words, and the block sequences back-to-back instructions without an idle cycle between them.

## Interface
Parameters:
- OPCODE_W, default 4: opcode width. Bits above [3:0] must be zero for a legal opcode.
- ALU_OT_W, default 2: ALU operation-type width.
- LDA_EXT, default 1: number of extension words for LDA. Range 1..(2**CNT_W − 1).
- CNT_W, default 2: width of the extension-word counter.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: sequencer enable.
- ins_ready, input, 1: instruction memory has a valid word this cycle.
- opcode, input, OPCODE_W: opcode field of the current instruction word.
- alu_ot, output, ALU_OT_W: ALU mode. 00 = addressing, 01 = arithmetic, 10 = logic.
- ins_load, output, 1: instruction splitter load strobe.
- pc_load, output, 1: PC-to-memory address load strobe.
- pc_inc, output, 1: PC increment strobe.
- op1_load, output, 1: operand-1 load strobe.
- op2_load, output, 1: operand-2 load strobe.
- reg_load, output, 1: register-file write strobe.
- instr_done, output, 1: one-cycle pulse in the final execute cycle of each instruction.
- trap, output, 1: illegal-opcode trap. Only present when CTRL_SEQ_TRAP_EN is defined; otherwise tied 0.

## Operation
- States: IDLE, FETCH, EXEC, EXT_FETCH, EXT_EXEC, TRAP.
- Outputs are Moore: a function of the state and the latched opcode cur_op only. There is no combinational path from opcode to any output.
- en=0: all outputs are forced to 0 combinationally. The state goes to IDLE on the next clock edge.
- IDLE: all outputs 0. Go to FETCH when en=1.
- FETCH: ins_load=1, pc_load=1.
  - ins_ready=1: capture opcode into cur_op and go to EXEC.
  - ins_ready=0: stay in FETCH (stall).
- EXEC strobes by opcode:
  - 0000–0011 (ADD/MUL/SUB/DIV): alu_ot=01, op1_load, op2_load, pc_inc, reg_load.
  - 0100–0110, 1001, 1010 (AND/OR/NOR/XOR/XNOR): alu_ot=10, op1_load, op2_load, pc_inc, reg_load.
  - 0111 (INV op1): alu_ot=10, op1_load, pc_inc, reg_load.
  - 1000 (INV op2): alu_ot=10, op2_load, pc_inc, reg_load.
  - 1011 (MOV): alu_ot=00, op2_load, pc_inc, reg_load.
  - 1100 (MVI): alu_ot=00, op1_load, pc_inc. Load cnt=1.
  - 1101 (LDA): alu_ot=00, pc_inc. Load cnt=LDA_EXT.
  - 1110 (NOP): pc_inc.
  - 1111, or any nonzero bit above [3:0]: illegal (see Configuration).
- EXEC exit: if cnt>0, go to EXT_FETCH. Otherwise assert instr_done and go to FETCH.
- EXT_FETCH: ins_load=1, pc_load=1, alu_ot=00. Waits on ins_ready exactly like FETCH, but does not recapture cur_op.
- EXT_EXEC: pc_inc=1, alu_ot=00, and cnt decrements.
  - MVI: op2_load=1, reg_load=1.
  - LDA: reg_load=1 only when cnt==1.
  - cnt==1: assert instr_done and go to FETCH. Otherwise go to EXT_FETCH.
- alu_ot is 00 in every state not listed above. It is never driven to Z.

## Timing
- Reset values: state=IDLE, cur_op=0, cnt=0, all outputs 0.
- Reset acts immediately on assertion, including mid-instruction; the partial instruction is abandoned.
- Latency with no stalls:
  - Single-word instruction: FETCH→EXEC, 2 cycles.
  - MVI: 4 cycles.
  - LDA: 2 + 2·LDA_EXT cycles.
- First FETCH occurs 1 cycle after en rises.
- Each ins_ready=0 cycle in FETCH or EXT_FETCH adds exactly one cycle of latency. Strobes stay high throughout the stall.
- en falling mid-instruction: outputs drop to 0 in the same cycle, and the next instruction restarts from IDLE.
- Back-to-back: the EXEC or last EXT_EXEC cycle is followed directly by FETCH; no IDLE cycle is inserted.
- pc_inc is asserted exactly once per instruction word consumed.

## Configuration
- CTRL_SEQ_TRAP_EN defined:
  - An illegal opcode in EXEC drives all strobes 0 and moves to TRAP.
  - In TRAP, trap=1 and all other outputs are 0.
  - TRAP is left only via en=0 (to IDLE) or rst_n=0.
- CTRL_SEQ_TRAP_EN undefined: an illegal opcode executes as NOP (pc_inc=1, instr_done=1) and the sequencer continues.

## Test plan
- Reset then en=1, ins_ready=1, opcode=0000 → FETCH (ins_load=1, pc_load=1), then EXEC (alu_ot=01, op1/op2/reg_load=1, pc_inc=1, instr_done=1), then FETCH.
- opcode=1100, ins_ready held 0 for 3 cycles in EXT_FETCH → 7 cycles total. op1_load in EXEC; op2_load and reg_load in EXT_EXEC; 2 pc_inc pulses.
- LDA_EXT=3, opcode=1101 → 8 cycles, 4 pc_inc pulses, reg_load only in the 3rd EXT_EXEC.
- opcode=1111 → with the macro: trap=1 until en=0, then IDLE. Without the macro: NOP behaviour and a FETCH next cycle.
- rst_n low during EXT_FETCH of MVI → all outputs 0 immediately; after release with en=1, FETCH follows 1 cycle later.
- en dropped during EXEC of 0111 → outputs 0 in the same cycle, IDLE next cycle; alu_ot is never Z.
